clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Programmable single-edge clock divider with a controller that sequences divide-ratio changes safely. The block runs from one clock. A valid/ready config port accepts a new ratio. A state machine applies the new ratio only at a period boundary, then holds the output low for a settle window, so div_clk_out never emits a runt pulse. It sits beside the fixed dividers and feeds downstream logic that needs a runtime-selectable slow clock or enable tick.

Parameters:
CNT_W, 4, counter/ratio width; legal ratio range 2..2^CNT_W-1
DEF_DIV, 2, ratio loaded at reset (must be 2..2^CNT_W-1)
SETTLE_CYC, 2, cycles div_clk_out is forced low after a ratio switch (>=1)

Ports:
clk_in  in  1  sole clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  run request; level-sensitive
cfg_valid  in  1  new ratio offered
cfg_div  in  CNT_W  requested ratio
cfg_ready  out  1  comb: high in IDLE or RUN
cfg_err  out  1  registered 1-cycle pulse, accepted cfg_div < 2 (rejected)
div_clk_out  out  1  registered divided clock
tick  out  1  registered 1-cycle pulse in last cycle of each period
cur_div  out  CNT_W  ratio currently in effect
busy  out  1  comb: state != IDLE

Behaviour:
- States: IDLE, RUN, DRAIN, SETTLE. Reset (async): IDLE, cnt=0, cur_div=DEF_DIV, pend=0, div_clk_out=0, tick=0, cfg_err=0.
- Handshake: a config is accepted when cfg_valid && cfg_ready. If cfg_div < 2: cfg_err=1 next cycle; state, cur_div and cnt are unchanged.
- IDLE: div_clk_out=0, tick=0, cnt=0.
  - Legal accept: cur_div <= cfg_div next cycle.
  - en=1: RUN next cycle with cnt=0. An accept and en in the same cycle are both honoured; the new ratio applies from the first period.
- RUN: cnt <= (cnt==cur_div-1) ? 0 : cnt+1.
  - div_clk_out is high in cycles where cnt < cur_div>>1, low otherwise.
  - Example div=3: high 1 cycle, low 2. Example div=4: high 2, low 2.
  - tick is high in the cycle where cnt==cur_div-1.
  - First output cycle after IDLE->RUN: cnt=0, div_clk_out=1.
  - Legal accept: pend <= cfg_div, then DRAIN.
  - en=0: DRAIN with no pending ratio.
- DRAIN: keep counting with the old cur_div; cfg_ready=0. At cnt==cur_div-1 (tick cycle), transition next cycle:
  - pending and en=1: SETTLE; cur_div <= pend; cnt=0; div_clk_out=0.
  - pending and en=0: IDLE; cur_div <= pend.
  - no pending: IDLE if en=0, else RUN with cnt=0 (en re-asserted before boundary, so the drain is cancelled seamlessly).
- SETTLE: div_clk_out=0, tick=0; a counter runs for SETTLE_CYC cycles, then RUN with cnt=0. en=0 during SETTLE: go to IDLE at the end of the settle window.
- div_clk_out and tick are decoded from next-state/next-cnt and registered; there are no combinational paths to them.
- cfg_err does not affect tick or div_clk_out timing.
- rst mid-operation: immediate return to reset values; pending ratio discarded; cur_div=DEF_DIV.

Optional Feature:
CLK_DIV_CTRL_PCNT_EN: when defined, adds output period_cnt [15:0].
- Increments on each tick; saturates at 16'hFFFF.
- Clears on rst and on every legal ratio application (cur_div update).
When undefined: the port and its logic are absent.

Test Plan:
- Reset, en=1, DEF_DIV=2 -> div_clk_out toggles 1,0,1,0 starting the cycle after en; tick on every low cycle; cur_div=2.
- Running div=2, offer cfg_div=5 mid-period -> current period completes; div_clk_out low 2 cycles (SETTLE); then high 2, low 3 repeating; tick every 5th cycle.
- cfg_div=1 in RUN -> cfg_err pulses 1 cycle; cur_div stays; no DRAIN; waveform uninterrupted.
- Running div=4, drop en at cnt=1 -> output completes high,low,low (cnt 1..3); tick once; IDLE; busy=0; div_clk_out=0.
- In IDLE, cfg_div=3 with en=1 same cycle -> first period uses ratio 3: high 1, low 2.
- Assert rst during SETTLE -> outputs 0 immediately; cur_div=DEF_DIV; state IDLE; pending ratio lost.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Programmable single-edge clock divider whose ratio changes are applied only at period
// boundaries, followed by a forced-low settle window. Define CLK_DIV_CTRL_PCNT_EN to add period_cnt.
module clk_div_ctrl #(
    parameter int CNT_W      = 4,
    parameter int DEF_DIV    = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] cur_div,
    output logic             busy
`ifdef CLK_DIV_CTRL_PCNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    localparam int            SC_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYC - 1);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [CNT_W-1:0] div_n;
    logic [CNT_W-1:0] pend, pend_n;
    logic             pend_v, pend_v_n;
    logic [SC_W-1:0]  scnt, scnt_n;
    logic             accept, legal, wrap;
    logic             err_n, run_n, clk_n, tick_n;

    assign cfg_ready = (state == S_IDLE) || (state == S_RUN);
    assign busy      = (state != S_IDLE);
    assign accept    = cfg_valid && cfg_ready;
    assign legal     = (cfg_div >= CNT_W'(2));
    assign wrap      = (cnt == cur_div - CNT_W'(1));
    assign cnt_inc   = wrap ? '0 : cnt + CNT_W'(1);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        div_n    = cur_div;
        pend_n   = pend;
        pend_v_n = pend_v;
        scnt_n   = scnt;
        err_n    = accept && !legal;

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (accept && legal) div_n = cfg_div;
                if (en) state_n = S_RUN;
            end
            S_RUN: begin
                cnt_n = cnt_inc;
                if (accept && legal) begin
                    pend_n   = cfg_div;
                    pend_v_n = 1'b1;
                    state_n  = S_DRAIN;
                end else if (!en) begin
                    pend_v_n = 1'b0;
                    state_n  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_n = cnt_inc;
                if (wrap) begin
                    pend_v_n = 1'b0;
                    if (pend_v) begin
                        div_n   = pend;
                        state_n = en ? S_SETTLE : S_IDLE;
                    end else begin
                        state_n = en ? S_RUN : S_IDLE;
                    end
                end
            end
            default: begin
                cnt_n  = '0;
                scnt_n = scnt + SC_W'(1);
                if (scnt == SC_LAST) begin
                    scnt_n  = '0;
                    state_n = en ? S_RUN : S_IDLE;
                end
            end
        endcase

        // Outputs are decoded from the next state so the registers line up with cnt/cur_div.
        run_n  = (state_n == S_RUN) || (state_n == S_DRAIN);
        clk_n  = run_n && (cnt_n < (div_n >> 1));
        tick_n = run_n && (cnt_n == div_n - CNT_W'(1));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cur_div     <= CNT_W'(DEF_DIV);
            pend        <= '0;
            pend_v      <= 1'b0;
            scnt        <= '0;
            div_clk_out <= 1'b0;
            tick        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cur_div     <= div_n;
            pend        <= pend_n;
            pend_v      <= pend_v_n;
            scnt        <= scnt_n;
            div_clk_out <= clk_n;
            tick        <= tick_n;
            cfg_err     <= err_n;
        end
    end

`ifdef CLK_DIV_CTRL_PCNT_EN
    logic div_load;
    assign div_load = ((state == S_IDLE) && accept && legal) ||
                      ((state == S_DRAIN) && wrap && pend_v);

    // A ratio load wins over a coincident tick so the count restarts for the new ratio.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (div_load) begin
            period_cnt <= '0;
        end else if (tick && (period_cnt != 16'hFFFF)) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random traffic checked
// against a period/position reference model.
module tb_clk_div_ctrl;

    localparam int CNT_W      = 4;
    localparam int DEF_DIV    = 2;
    localparam int SETTLE_CYC = 2;

    logic             clk_in = 1'b0;
    logic             rst, en, cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready, cfg_err, div_clk_out, tick, busy;
    logic [CNT_W-1:0] cur_div;
    logic [CNT_W+4:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Reference model: a period position within the active ratio, a drain flag and a settle countdown.
    bit m_active, m_drain, m_have, m_err;
    int m_pend, m_pos, m_div, m_settle;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .div_clk_out (div_clk_out),
        .tick        (tick),
        .cur_div     (cur_div),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    assign dut_vec = {cfg_ready, cfg_err, div_clk_out, tick, cur_div, busy};

    function automatic logic [CNT_W+4:0] exp_vec();
        logic rdy, clk_e, tick_e, busy_e;
        rdy    = !m_drain && (m_settle == 0);
        clk_e  = m_active && (m_pos < m_div / 2);
        tick_e = m_active && (m_pos == m_div - 1);
        busy_e = m_active || (m_settle > 0);
        return {rdy, m_err, clk_e, tick_e, CNT_W'(m_div), busy_e};
    endfunction

    task automatic model_reset();
        m_active = 0; m_drain = 0; m_have = 0; m_err = 0;
        m_pend = 0; m_pos = 0; m_div = DEF_DIV; m_settle = 0;
    endtask

    task automatic model_step(input bit e, input bit v, input int d);
        bit rdy, acc, ok, last;
        rdy   = !m_drain && (m_settle == 0);
        acc   = v && rdy;
        ok    = (d >= 2);
        m_err = acc && !ok;
        if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0 && e) begin m_active = 1; m_pos = 0; end
        end else if (!m_active) begin
            if (acc && ok) m_div = d;
            if (e) begin m_active = 1; m_pos = 0; end
        end else begin
            last  = (m_pos == m_div - 1);
            m_pos = last ? 0 : m_pos + 1;
            if (!m_drain) begin
                if (acc && ok) begin m_drain = 1; m_have = 1; m_pend = d; end
                else if (!e)   begin m_drain = 1; m_have = 0; end
            end else if (last) begin
                m_drain = 0;
                if (m_have) begin
                    m_div = m_pend; m_have = 0; m_active = 0;
                    if (e) m_settle = SETTLE_CYC;
                end else if (!e) begin
                    m_active = 0;
                end
            end
        end
    endtask

    // Drive inputs at a falling edge, advance the model across the next rising edge, land on the next falling edge.
    task automatic cycle(input bit e, input bit v, input int d);
        en        = e;
        cfg_valid = v;
        cfg_div   = CNT_W'(d);
        model_step(e, v, d);
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        model_reset();
        repeat (2) @(negedge clk_in);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", dut_vec, exp_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_default_run();
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL default_run model cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            checks++;
            if ({div_clk_out, tick} !== {(i % 2) == 0, (i % 2) == 1}) begin
                errors++;
                $display("FAIL default_run pattern cyc %0d: got clk=%b tick=%b expected clk=%b tick=%b",
                         i, div_clk_out, tick, (i % 2) == 0, (i % 2) == 1);
            end
        end
    endtask

    task automatic test_ratio_change();
        cycle(1, 1, 5);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL ratio_change cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (cur_div !== CNT_W'(5)) begin
            errors++;
            $display("FAIL ratio_change cur_div: got %0d expected 5", cur_div);
        end
    endtask

    task automatic test_illegal_cfg();
        int pulses = 0;
        cycle(1, 1, 1);
        for (int i = 0; i < 12; i++) begin
            if (cfg_err === 1'b1) pulses++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL illegal_cfg cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            cycle(1, 0, 0);
        end
        checks++;
        if (pulses != 1 || cur_div !== CNT_W'(5)) begin
            errors++;
            $display("FAIL illegal_cfg err_pulses/cur_div: got %0d/%0d expected 1/5", pulses, cur_div);
        end
    endtask

    task automatic test_drop_en();
        bit exp_clk[3]  = '{0, 0, 0};
        bit exp_tick[3] = '{0, 1, 0};
        bit exp_busy[3] = '{1, 1, 0};
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            cycle(0, 0, 0);
            n++;
        end
        checks++;
        if (busy !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL drop_en reach_idle: busy=%b got %h expected %h", busy, dut_vec, exp_vec());
        end
        cycle(1, 1, 4);
        cycle(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0);
            checks++;
            if ({div_clk_out, tick, busy} !== {exp_clk[i], exp_tick[i], exp_busy[i]} ||
                dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL drop_en cyc %0d: got clk/tick/busy=%b%b%b expected %b%b%b",
                         i, div_clk_out, tick, busy, exp_clk[i], exp_tick[i], exp_busy[i]);
            end
        end
    endtask

    task automatic test_idle_cfg_en();
        cycle(1, 1, 3);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({div_clk_out, tick, cur_div} !== {(i % 3) == 0, (i % 3) == 2, CNT_W'(3)} ||
                dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL idle_cfg_en cyc %0d: got clk=%b tick=%b div=%0d expected clk=%b tick=%b div=3",
                         i, div_clk_out, tick, cur_div, (i % 3) == 0, (i % 3) == 2);
            end
            cycle(1, 0, 0);
        end
    endtask

    task automatic test_reset_in_settle();
        int n = 0;
        cycle(1, 1, 7);
        while (m_settle == 0 && n < 20) begin
            cycle(1, 0, 0);
            n++;
        end
        checks++;
        if (m_settle == 0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_in_settle reach_settle: got %h expected %h after %0d cycles",
                     dut_vec, exp_vec(), n);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({div_clk_out, tick, busy, cfg_err, cfg_ready, cur_div} !== {5'b00001, CNT_W'(DEF_DIV)}) begin
            errors++;
            $display("FAIL reset_in_settle async: got clk/tick/busy/err/rdy=%b%b%b%b%b div=%0d expected 00001 div=%0d",
                     div_clk_out, tick, busy, cfg_err, cfg_ready, cur_div, DEF_DIV);
        end
        model_reset();
        @(negedge clk_in);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0);
            checks++;
            if (dut_vec !== exp_vec() || cur_div !== CNT_W'(DEF_DIV)) begin
                errors++;
                $display("FAIL reset_in_settle after cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, int'($urandom_range(0, 15)));
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_ratio_change();
        test_illegal_cfg();
        test_drop_en();
        test_idle_cfg_en();
        test_reset_in_settle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
